// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues dbus requests, tracks up to DEPTH outstanding
// transactions and returns in-order responses with lane extraction and address errors.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [31:0]             req_wdata,
    input  logic [TAG_W-1:0]        req_tag,
    input  logic                    flush,
    output logic                    resp_valid,
    output logic [TAG_W-1:0]        resp_tag,
    output logic [31:0]             resp_rdata,
    output logic                    resp_exc,
    output logic                    resp_exc_store,
    output logic [ADDR_W-1:0]       resp_badvaddr,
    output logic                    dreq_valid,
    output logic [ADDR_W-1:0]       dreq_addr,
    output logic [1:0]              dreq_size,
    output logic [3:0]              dreq_strobe,
    output logic [31:0]             dreq_data,
    input  logic                    dresp_addr_ok,
    input  logic                    dresp_data_ok,
    input  logic [31:0]             dresp_data,
    output logic [$clog2(DEPTH):0]  outstanding
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [1:0]       size;
        logic             sgn;
        logic [1:0]       off;
        logic             write;
        logic             killed;
    } entry_t;

    entry_t           trk [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic             issue_valid;
    logic             exc_pending;

    logic             misaligned;
    logic             base_ready;
    logic             accept;
    logic             accept_ok;
    logic             accept_exc;
    logic             pop;
    logic [3:0]       strobe_next;
    logic [31:0]      data_next;
    entry_t           head;
    logic [31:0]      shifted;
    logic [31:0]      load_data;

    // Size 3 behaves as a word, so only bit 1 of the size matters for word alignment.
    assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign base_ready = !reset && !flush && !issue_valid && !exc_pending &&
                        (count < CNT_W'(DEPTH));
    assign req_ready  = base_ready && (!misaligned || (count == '0));
    assign accept     = req_valid && req_ready;
    assign accept_ok  = accept && !misaligned;
    assign accept_exc = accept && misaligned;
    assign pop        = dresp_data_ok && (count != '0);
    assign outstanding = count;
    assign dreq_valid  = issue_valid;
    assign head        = trk[head_ptr];

    always_comb begin
        strobe_next = 4'b1111;
        data_next   = req_wdata;
        case (req_size)
            2'd0: begin
                strobe_next = 4'b0001 << req_addr[1:0];
                data_next   = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                strobe_next = 4'b0011 << {req_addr[1], 1'b0};
                data_next   = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!req_write) begin
            strobe_next = 4'b0000;
        end
    end

    always_comb begin
        shifted   = dresp_data >> {head.off, 3'b000};
        load_data = shifted;
        case (head.size)
            2'd0: load_data = {{24{head.sgn & shifted[7]}}, shifted[7:0]};
            2'd1: load_data = {{16{head.sgn & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
        if (head.write) begin
            load_data = 32'd0;
        end
    end

    // The issue register holds the dbus request steady until the bus takes the address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_valid <= 1'b0;
            dreq_addr   <= '0;
            dreq_size   <= 2'd0;
            dreq_strobe <= 4'd0;
            dreq_data   <= 32'd0;
        end else if (accept_ok) begin
            issue_valid <= 1'b1;
            dreq_addr   <= req_addr;
            dreq_size   <= req_size;
            dreq_strobe <= strobe_next;
            dreq_data   <= data_next;
        end else if (issue_valid && dresp_addr_ok) begin
            issue_valid <= 1'b0;
            dreq_addr   <= '0;
            dreq_size   <= 2'd0;
            dreq_strobe <= 4'd0;
            dreq_data   <= 32'd0;
        end
    end

    // Killed entries keep their slot so data_ok pops stay aligned with the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                trk[i] <= '0;
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    trk[i].killed <= 1'b1;
                end
            end
            if (accept_ok) begin
                trk[tail_ptr] <= '{tag: req_tag, size: req_size, sgn: req_signed,
                                   off: req_addr[1:0], write: req_write, killed: 1'b0};
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            if (accept_ok && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!accept_ok && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Exceptions only issue with an empty tracker, so they never collide with a pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_pending    <= 1'b0;
            resp_valid     <= 1'b0;
            resp_tag       <= '0;
            resp_rdata     <= 32'd0;
            resp_exc       <= 1'b0;
            resp_exc_store <= 1'b0;
            resp_badvaddr  <= '0;
        end else begin
            exc_pending    <= accept_exc;
            resp_valid     <= 1'b0;
            resp_tag       <= '0;
            resp_rdata     <= 32'd0;
            resp_exc       <= 1'b0;
            resp_exc_store <= 1'b0;
            resp_badvaddr  <= '0;
            if (accept_exc) begin
                resp_valid     <= 1'b1;
                resp_tag       <= req_tag;
                resp_exc       <= 1'b1;
                resp_exc_store <= req_write;
                resp_badvaddr  <= req_addr;
            end else if (pop && !head.killed && !flush) begin
                resp_valid <= 1'b1;
                resp_tag   <= head.tag;
                resp_rdata <= load_data;
            end
        end
    end

    a_no_empty_pop: assert property (@(posedge clk) disable iff (reset)
        !(dresp_data_ok && (count == '0)));

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases plus random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_tag;
    logic        flush;
    logic        resp_valid;
    logic [3:0]  resp_tag;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic        resp_exc_store;
    logic [31:0] resp_badvaddr;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;
    logic [2:0]  outstanding;

    mem_access_unit #(.ADDR_W(32), .TAG_W(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag), .flush(flush),
        .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_rdata(resp_rdata),
        .resp_exc(resp_exc), .resp_exc_store(resp_exc_store), .resp_badvaddr(resp_badvaddr),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        bit          killed;
    } txn_t;

    txn_t        mq[$];
    int          nAddressed = 0;
    bit          issuePend  = 0;
    bit          excPrev    = 0;
    bit          erValid    = 0;
    logic [3:0]  erTag      = '0;
    logic [31:0] erRdata    = '0;
    bit          erExc      = 0;
    bit          erStore    = 0;
    logic [31:0] erBad      = '0;
    int          errors     = 0;
    int          checks     = 0;

    logic [3:0]  capStrobe;
    logic [31:0] capData;
    logic        capValid;
    logic [31:0] capRdata;

    bit          rRv, rRw, rSg, rFl, rAok, rDok;
    logic [1:0]  rSz;
    logic [31:0] rAd;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int bytesOf(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit isMis(input logic [1:0] size, input logic [31:0] addr);
        return (int'(addr[1:0]) % bytesOf(size)) != 0;
    endfunction

    function automatic logic [31:0] refLoad(input logic [1:0] size, input logic sgn,
                                             input logic [1:0] off, input logic [31:0] raw);
        logic [31:0] v;
        v = raw >> (8 * int'(off));
        if (size == 2'd0) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'h80) v = v - 32'h100;
        end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    function automatic logic [3:0] refStrobe(input logic [1:0] size, input logic [31:0] addr,
                                             input logic write);
        logic [3:0] s;
        int off;
        s = 4'b0000;
        off = int'(addr[1:0]);
        for (int b = 0; b < 4; b++) begin
            if (write && b >= off && b < off + bytesOf(size)) s[b] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [31:0] refData(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return {24'h0, wd[7:0]} * 32'h01010101;
        if (size == 2'd1) return {16'h0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic applyStimulus(input bit rv, input bit rw, input logic [1:0] sz, input bit sg,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [3:0] tg, input bit fl, input bit aok,
                                 input bit dok, input logic [31:0] dd);
        bit   mis, expReady, acc;
        txn_t t;
        bit   nValid, nExc, nStore;
        logic [3:0]  nTag;
        logic [31:0] nRdata, nBad;

        @(negedge clk);
        req_valid = rv; req_write = rw; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd; req_tag = tg; flush = fl;
        dresp_addr_ok = aok; dresp_data_ok = dok; dresp_data = dd;
        #1;
        mis = isMis(sz, addr);
        expReady = !fl && !issuePend && (mq.size() < 4) && !excPrev && (!mis || mq.size() == 0);
        checkOutput("req_ready", req_ready, expReady);
        checkOutput("outstanding", outstanding, mq.size());
        checkOutput("resp_valid", resp_valid, erValid);
        if (erValid) begin
            checkOutput("resp_tag", resp_tag, erTag);
            checkOutput("resp_rdata", resp_rdata, erRdata);
            checkOutput("resp_exc", resp_exc, erExc);
            checkOutput("resp_exc_store", resp_exc_store, erStore);
            checkOutput("resp_badvaddr", resp_badvaddr, erBad);
        end
        checkOutput("dreq_valid", dreq_valid, issuePend);
        if (issuePend) begin
            t = mq[$];
            checkOutput("dreq_addr", dreq_addr, t.addr);
            checkOutput("dreq_size", dreq_size, t.size);
            checkOutput("dreq_strobe", dreq_strobe, refStrobe(t.size, t.addr, t.write));
            checkOutput("dreq_data", dreq_data, refData(t.size, t.wdata));
        end

        nValid = 0; nTag = '0; nRdata = '0; nExc = 0; nStore = 0; nBad = '0;
        if (fl) begin
            for (int i = 0; i < mq.size(); i++) mq[i].killed = 1;
        end
        if (issuePend && aok) begin
            issuePend = 0;
            nAddressed++;
        end
        if (dok && mq.size() > 0) begin
            t = mq.pop_front();
            nAddressed--;
            if (!t.killed) begin
                nValid = 1;
                nTag   = t.tag;
                nRdata = t.write ? 32'd0 : refLoad(t.size, t.sgn, t.addr[1:0], dd);
            end
        end
        acc = rv && expReady;
        if (acc && mis) begin
            nValid = 1; nTag = tg; nExc = 1; nStore = rw; nBad = addr; nRdata = '0;
        end else if (acc) begin
            mq.push_back('{tag: tg, size: sz, sgn: sg, addr: addr, write: rw, wdata: wd, killed: 0});
            issuePend = 1;
        end
        excPrev = acc && mis;
        erValid = nValid; erTag = nTag; erRdata = nRdata;
        erExc = nExc; erStore = nStore; erBad = nBad;
    endtask

    task automatic idleCycle(input bit aok, input bit dok, input logic [31:0] dd);
        applyStimulus(0, 0, 2'd0, 0, 32'd0, 32'd0, 4'd0, 0, aok, dok, dd);
    endtask

    task automatic issueReq(input bit rw, input logic [1:0] sz, input bit sg,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] tg);
        applyStimulus(1, rw, sz, sg, addr, wd, tg, 0, 0, 0, 32'd0);
    endtask

    // Accept, then addr_ok and data_ok together, then observe the response.
    task automatic oneShot(input bit rw, input logic [1:0] sz, input bit sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] dd, input logic [3:0] tg);
        issueReq(rw, sz, sg, addr, wd, tg);
        idleCycle(1, 1, dd);
        capStrobe = dreq_strobe;
        capData   = dreq_data;
        idleCycle(0, 0, 32'd0);
        capValid = resp_valid;
        capRdata = resp_rdata;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; req_tag = 0; flush = 0;
        dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_dreq_valid", dreq_valid, 0);
        checkOutput("rst_outstanding", outstanding, 0);
        @(negedge clk);
        reset = 1'b0;

        oneShot(0, 2'd2, 0, 32'h100, 32'd0, 32'hDEADBEEF, 4'd1);
        checkOutput("lw_valid", capValid, 1);
        checkOutput("lw_rdata", capRdata, 32'hDEADBEEF);
        oneShot(0, 2'd0, 1, 32'h103, 32'd0, 32'h80FFFFFF, 4'd2);
        checkOutput("lb_rdata", capRdata, 32'hFFFFFF80);
        oneShot(0, 2'd0, 0, 32'h103, 32'd0, 32'h80FFFFFF, 4'd2);
        checkOutput("lbu_rdata", capRdata, 32'h00000080);
        oneShot(0, 2'd1, 0, 32'h102, 32'd0, 32'h1234ABCD, 4'd3);
        checkOutput("lhu_rdata", capRdata, 32'h00001234);
        oneShot(1, 2'd1, 0, 32'h106, 32'h5A5A, 32'h0, 4'd4);
        checkOutput("sh_strobe", capStrobe, 4'b1100);
        checkOutput("sh_data", capData, 32'h5A5A5A5A);
        checkOutput("sh_rdata", capRdata, 32'h0);
        oneShot(1, 2'd0, 0, 32'h101, 32'h11, 32'h0, 4'd5);
        checkOutput("sb_strobe", capStrobe, 4'b0010);
        checkOutput("sb_data", capData, 32'h11111111);

        for (int i = 0; i < 4; i++) begin
            issueReq(0, 2'd2, 0, 32'h200 + 4 * i, 32'd0, 4'(4 + i));
            idleCycle(1, 0, 32'd0);
        end
        applyStimulus(1, 0, 2'd2, 0, 32'h300, 32'd0, 4'd15, 0, 0, 0, 32'd0);
        checkOutput("full_ready", req_ready, 0);
        checkOutput("full_outstanding", outstanding, 4);
        applyStimulus(1, 0, 2'd2, 0, 32'h300, 32'd0, 4'd15, 0, 0, 1, 32'h1000);
        checkOutput("full_ready_pop", req_ready, 0);
        for (int i = 1; i < 4; i++) begin
            idleCycle(0, 1, 32'h1000 + i);
            checkOutput("fill_tag", resp_tag, 4'(3 + i));
        end
        idleCycle(0, 0, 32'd0);
        checkOutput("fill_tag_last", resp_tag, 4'd7);
        checkOutput("fill_rdata_last", resp_rdata, 32'h1003);

        for (int i = 0; i < 2; i++) begin
            issueReq(0, 2'd2, 0, 32'h400 + 4 * i, 32'd0, 4'(i));
            idleCycle(1, 0, 32'd0);
        end
        applyStimulus(1, 0, 2'd2, 0, 32'h102, 32'd0, 4'd9, 0, 0, 0, 32'd0);
        checkOutput("mis_held", req_ready, 0);
        applyStimulus(1, 0, 2'd2, 0, 32'h102, 32'd0, 4'd9, 0, 0, 1, 32'h55);
        applyStimulus(1, 0, 2'd2, 0, 32'h102, 32'd0, 4'd9, 0, 0, 1, 32'h66);
        checkOutput("mis_held_one", req_ready, 0);
        applyStimulus(1, 0, 2'd2, 0, 32'h102, 32'd0, 4'd9, 0, 0, 0, 32'd0);
        checkOutput("mis_ready", req_ready, 1);
        idleCycle(0, 0, 32'd0);
        checkOutput("adel_exc", resp_exc, 1);
        checkOutput("adel_store", resp_exc_store, 0);
        checkOutput("adel_badvaddr", resp_badvaddr, 32'h102);
        issueReq(1, 2'd2, 0, 32'h101, 32'h0, 4'd10);
        idleCycle(0, 0, 32'd0);
        checkOutput("ades_exc", resp_exc, 1);
        checkOutput("ades_store", resp_exc_store, 1);
        checkOutput("ades_badvaddr", resp_badvaddr, 32'h101);

        for (int i = 0; i < 3; i++) begin
            issueReq(0, 2'd2, 0, 32'h500 + 4 * i, 32'd0, 4'(i));
            idleCycle(1, 0, 32'd0);
        end
        applyStimulus(0, 0, 2'd0, 0, 32'd0, 32'd0, 4'd0, 1, 0, 0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            idleCycle(0, 1, 32'hABCD0000 + i);
            checkOutput("flush_quiet", resp_valid, 0);
        end
        idleCycle(0, 0, 32'd0);
        checkOutput("flush_quiet_last", resp_valid, 0);
        oneShot(0, 2'd2, 0, 32'h104, 32'd0, 32'hCAFEF00D, 4'd6);
        checkOutput("post_flush_valid", capValid, 1);
        checkOutput("post_flush_rdata", capRdata, 32'hCAFEF00D);

        for (int c = 0; c < 3000; c++) begin
            rRv  = ($urandom_range(0, 3) != 0);
            rRw  = 1'($urandom_range(0, 1));
            rSz  = 2'($urandom_range(0, 3));
            rSg  = 1'($urandom_range(0, 1));
            rAd  = $urandom & 32'h0000_0FFF;
            rFl  = ($urandom_range(0, 19) == 0);
            rAok = 1'($urandom_range(0, 1));
            rDok = (nAddressed > 0 || (issuePend && rAok)) && ($urandom_range(0, 2) != 0);
            applyStimulus(rRv, rRw, rSz, rSg, rAd, $urandom, 4'($urandom), rFl, rAok, rDok,
                          $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
